// File: rtl/flap_pkg.sv
// Shared constants, field slices and state encoding for the flappy-bird autopilot.
// Geometry is in screen pixels; the game advances one step per 100 ms tick.
package flap_pkg;

    localparam int BIRD_X   = 40;
    localparam int BIRD_H   = 16;
    localparam int PIPE_W   = 50;
    localparam int SCREEN_W = 640;

    localparam int P_GAP_HI = 27;
    localparam int P_GAP_LO = 20;
    localparam int P_X_HI   = 19;
    localparam int P_X_LO   = 10;
    localparam int P_Y_HI   = 9;
    localparam int P_Y_LO   = 0;
    localparam int B_Y_HI   = 14;
    localparam int B_Y_LO   = 0;
    localparam int B_RISE   = 15;

    localparam logic [1:0] ST_RUN1  = 2'b00;
    localparam logic [1:0] ST_RUN2  = 2'b11;
    localparam logic [1:0] ST_RST_A = 2'b01;
    localparam logic [1:0] ST_RST_B = 2'b10;

    typedef enum logic [1:0] {
        AP_IDLE  = 2'd0,
        AP_TRACK = 2'd1,
        AP_FLAP  = 2'd2,
        AP_COOL  = 2'd3
    } ap_state_t;

    function automatic logic is_running(input logic [1:0] s);
        return (s == ST_RUN1) || (s == ST_RUN2);
    endfunction

endpackage

// File: rtl/flap_target_sel.sv
// Picks the nearest pipe still ahead of the bird and returns its gap centre.
// Falls back to IDLE_TARGET with index 0 when nothing qualifies.
module flap_target_sel
    import flap_pkg::*;
#(
    parameter int IDLE_TARGET = 240
) (
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    output logic [1:0]  target,
    output logic [10:0] tc
);

    logic [31:0] pw [3];
    logic        unused_bits;

    assign pw[0] = pipe1;
    assign pw[1] = pipe2;
    assign pw[2] = pipe3;

    assign unused_bits = ^{pipe1[31:28], pipe2[31:28], pipe3[31:28]};

    always_comb begin
        logic       found;
        logic [9:0] best;
        logic [9:0] xi;
        logic [9:0] yi;
        logic [7:0] gi;
        found  = 1'b0;
        best   = '0;
        target = 2'd0;
        tc     = 11'(IDLE_TARGET);
        for (int i = 0; i < 3; i++) begin
            xi = pw[i][P_X_HI:P_X_LO];
            yi = pw[i][P_Y_HI:P_Y_LO];
            gi = pw[i][P_GAP_HI:P_GAP_LO];
            // strict < keeps the lower index on equal x
            if ((({1'b0, xi} + 11'(PIPE_W)) >= 11'(BIRD_X)) &&
                (!found || (xi < best))) begin
                found  = 1'b1;
                best   = xi;
                target = 2'(i + 1);
                tc     = {1'b0, yi} + {4'b0, gi[7:1]};
            end
        end
    end

endmodule

// File: rtl/flap_autopilot.sv
// Autopilot FSM: tracks the selected gap centre and issues rate-limited flaps.
// up is registered, so a flap decided at edge n appears at edge n+1.
module flap_autopilot
    import flap_pkg::*;
#(
    parameter int MARGIN      = 4,
    parameter int COOLDOWN    = 6,
    parameter int CEIL_MIN    = 30,
    parameter int IDLE_TARGET = 240
) (
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  status,
    input  logic [15:0] bird_y,
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    output logic        up,
    output logic [1:0]  target,
    output logic [15:0] flap_count
);

    ap_state_t   state;
    logic [7:0]  cool_cnt;
    logic [1:0]  sel;
    logic [10:0] tc;
    logic [15:0] by;
    logic [15:0] bc;
    logic [15:0] lim;
    logic        want_flap;
    logic        run;
    logic        unused_bits;

    flap_target_sel #(
        .IDLE_TARGET(IDLE_TARGET)
    ) u_sel (
        .pipe1 (pipe1),
        .pipe2 (pipe2),
        .pipe3 (pipe3),
        .target(sel),
        .tc    (tc)
    );

    assign unused_bits = bird_y[B_RISE];
    assign by          = {1'b0, bird_y[B_Y_HI:B_Y_LO]};
    assign bc          = by + 16'(BIRD_H / 2);
    assign lim         = {5'b0, tc} + 16'(MARGIN);
    assign want_flap   = (bc > lim) && (by >= 16'(CEIL_MIN));
    assign run         = enable && is_running(status);

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state      <= AP_IDLE;
            up         <= 1'b0;
            target     <= 2'd0;
            flap_count <= 16'd0;
            cool_cnt   <= 8'd0;
        end else begin
            target <= sel;
            if (!run) begin
                state    <= AP_IDLE;
                up       <= 1'b0;
                cool_cnt <= 8'd0;
            end else begin
                unique case (state)
                    AP_IDLE: begin
                        up       <= 1'b0;
                        cool_cnt <= 8'd0;
                        state    <= AP_TRACK;
                    end
                    AP_TRACK: begin
                        up <= 1'b0;
                        if (want_flap) state <= AP_FLAP;
                    end
                    AP_FLAP: begin
                        up         <= 1'b1;
                        flap_count <= flap_count + 16'd1;
                        cool_cnt   <= 8'(COOLDOWN);
                        state      <= (COOLDOWN == 0) ? AP_TRACK : AP_COOL;
                    end
                    AP_COOL: begin
                        up <= 1'b0;
                        if (cool_cnt != 8'd0) cool_cnt <= cool_cnt - 8'd1;
                        if (cool_cnt <= 8'd1) state <= AP_TRACK;
                    end
                    default: state <= AP_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flap_autopilot.sv
// Directed bench for flap_autopilot: flap timing, selection, guards and wrap.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_flap_autopilot;
    import flap_pkg::*;

    logic        clk_100ms = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  status;
    logic [15:0] bird_y;
    logic [31:0] pipe1;
    logic [31:0] pipe2;
    logic [31:0] pipe3;
    logic        up;
    logic [1:0]  target;
    logic [15:0] flap_count;

    int n_chk  = 0;
    int n_fail = 0;

    flap_autopilot dut (
        .clk_100ms (clk_100ms),
        .rst       (rst),
        .enable    (enable),
        .status    (status),
        .bird_y    (bird_y),
        .pipe1     (pipe1),
        .pipe2     (pipe2),
        .pipe3     (pipe3),
        .up        (up),
        .target    (target),
        .flap_count(flap_count)
    );

    always #5 clk_100ms = ~clk_100ms;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pw(input int gap, input int x,
                                       input int y);
        logic [31:0] g;
        logic [31:0] xv;
        logic [31:0] yv;
        g  = gap;
        xv = x;
        yv = y;
        return {4'h0, g[7:0], xv[9:0], yv[9:0]};
    endfunction

    task automatic wait_up(input int lim, output int n);
        n = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk_100ms);
            if (up) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_ups(input int len, output int n);
        n = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk_100ms);
            if (up) n++;
        end
    endtask

    int k;

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        status = ST_RST_A;
        bird_y = 16'd0;
        pipe1  = '0;
        pipe2  = '0;
        pipe3  = '0;
        repeat (2) @(negedge clk_100ms);
        chk("rst_up", 32'(up), 0);
        chk("rst_target", 32'(target), 0);
        chk("rst_count", 32'(flap_count), 0);

        // bc 248 > tc 210 + 4
        rst    = 1'b1;
        enable = 1'b1;
        status = ST_RUN1;
        pipe1  = pw(120, 100, 150);
        pipe2  = pw(120, 310, 150);
        pipe3  = pw(120, 520, 150);
        bird_y = 16'd240;
        @(negedge clk_100ms);
        chk("flap_target", 32'(target), 1);
        chk("flap_up_e1", 32'(up), 0);
        @(negedge clk_100ms);
        chk("flap_up_e2", 32'(up), 0);
        @(negedge clk_100ms);
        chk("flap_up_e3", 32'(up), 1);
        chk("flap_count1", 32'(flap_count), 1);
        wait_up(20, k);
        chk("flap_spacing", 32'(k), 8);
        chk("flap_count2", 32'(flap_count), 2);

        // asynchronous reset while up is high
        #1 rst = 1'b0;
        #1;
        chk("midrst_up", 32'(up), 0);
        chk("midrst_count", 32'(flap_count), 0);
        chk("midrst_target", 32'(target), 0);
        bird_y = 16'd195;
        @(negedge clk_100ms);
        rst = 1'b1;

        // bc 203 <= 214: hold in TRACK
        count_ups(12, k);
        chk("below_ups", 32'(k), 0);
        chk("below_state", 32'(dut.state), 32'(AP_TRACK));
        chk("below_count", 32'(flap_count), 0);

        pipe1 = pw(120, 5, 150);
        pipe2 = pw(120, 200, 150);
        pipe3 = pw(120, 400, 150);
        @(negedge clk_100ms);
        chk("sel_x5", 32'(target), 1);
        pipe1 = pw(120, 0, 150);
        pipe2 = pw(120, 0, 150);
        @(negedge clk_100ms);
        chk("sel_tie12", 32'(target), 1);
        pipe1 = pw(120, 200, 150);
        pipe2 = pw(120, 50, 150);
        pipe3 = pw(120, 50, 150);
        @(negedge clk_100ms);
        chk("sel_tie23", 32'(target), 2);
        pipe3 = pw(120, 10, 150);
        @(negedge clk_100ms);
        chk("sel_p3", 32'(target), 3);
        // x + 50 fits in 11 bits, so x = 700 still counts as ahead
        pipe1 = pw(120, 700, 150);
        pipe2 = pw(120, 700, 150);
        pipe3 = pw(120, 700, 150);
        @(negedge clk_100ms);
        chk("sel_x700", 32'(target), 1);
        chk("sel_noflap", 32'(flap_count), 0);

        // tc = 0: only the ceiling guard blocks the flap
        pipe1  = pw(0, 100, 0);
        pipe2  = pw(0, 300, 0);
        pipe3  = pw(0, 500, 0);
        bird_y = 16'd20;
        count_ups(10, k);
        chk("ceil_ups", 32'(k), 0);
        bird_y = 16'd30;
        wait_up(5, k);
        chk("ceil_edge_lat", 32'(k), 2);
        chk("ceil_count", 32'(flap_count), 1);
        @(negedge clk_100ms);
        chk("cool_state", 32'(dut.state), 32'(AP_COOL));
        status = ST_RST_A;
        @(negedge clk_100ms);
        chk("abort_state", 32'(dut.state), 32'(AP_IDLE));
        chk("abort_up", 32'(up), 0);
        status = ST_RUN2;
        bird_y = 16'd20;
        @(negedge clk_100ms);
        chk("resume_state", 32'(dut.state), 32'(AP_TRACK));
        enable = 1'b0;
        @(negedge clk_100ms);
        chk("disable_state", 32'(dut.state), 32'(AP_IDLE));
        enable = 1'b1;
        repeat (3) @(negedge clk_100ms);

        force dut.flap_count = 16'hFFFF;
        #1 release dut.flap_count;
        @(negedge clk_100ms);
        chk("wrap_pre", 32'(flap_count), 32'hFFFF);
        bird_y = 16'd30;
        wait_up(5, k);
        chk("wrap_lat", 32'(k), 2);
        chk("wrap_count", 32'(flap_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
